arm_multicycle_datapath: RTL and testbench
==========================================

Name: arm_multicycle_datapath

Overview:
- Parametrised multicycle successor of the single-cycle ARM datapath.
- Uses one unified memory port and non-architectural state registers: IR, Data, A, WriteData, ALUOut.
- Adds a built-in barrel shifter on the register operand and a MOV/shift result path.
- An external multicycle controller FSM drives all enables and selects; this block holds every piece of datapath state.

Parameters:
- WIDTH, 32, datapath and register width; instruction fields are always decoded from Instr[31:0]; WIDTH must be at least 32.
- RESET_PC, 0, PC value loaded on reset.
- SHIFT_EN, 1, when 1 instantiates the barrel shifter; when 0 SrcB uses WriteData unshifted.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- PCWrite  in  1  PC load enable.
- AdrSrc  in  1  0: Adr=PC; 1: Adr=Result.
- IRWrite  in  1  IR load enable.
- RegSrc  in  2  [0]: RA1=15; [1]: RA2=Instr[15:12].
- RegWrite  in  1  register file write enable (Rd=Instr[15:12]).
- ImmSrc  in  2  extend mode: 00 imm8, 01 imm12, 10 branch imm24<<2.
- ALUSrcA  in  1  0: A register; 1: PC.
- ALUSrcB  in  2  00: shifted WriteData; 01: ExtImm; 10: constant 4.
- ALUControl  in  2  00 add, 01 sub, 10 and, 11 orr.
- ShiftOp  in  1  1: ALUResult=SrcB (MOV/LSL/LSR/ASR/ROR).
- ResultSrc  in  2  00: ALUOut; 01: Data; 10: ALUResult.
- Adr  out  WIDTH  memory address.
- WriteData  out  WIDTH  registered RD2, the store data.
- ReadData  in  WIDTH  memory read data.
- Instr  out  32  IR contents.
- ALUFlags  out  4  {N,Z,C,V} of the current ALUResult, combinational.

Behaviour:
- Reset (async, immediate): PC=RESET_PC; IR, Data, A, WriteData, ALUOut=0; register file contents unaffected.
  - Therefore Adr=RESET_PC with AdrSrc=0, Instr=0, and ALUFlags reflect the zeroed state.
- PC and IR load only on enable. Data, A, WriteData and ALUOut load every clock, one cycle after their combinational source.
- Result is a combinational mux per ResultSrc. PCNext=Result.
  - In fetch the controller selects PC+4 (ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1).
- R15 reads return PC+4. The PC has already advanced in fetch, so this equals instruction address+8.
  - RA1 and RA2 both obey this rule.
- Register file: write on rising edge when RegWrite. A write to R15 is ignored; PC updates only via PCWrite. Reads are combinational.
- Shifter (SHIFT_EN=1), on the WriteData register:
  - shamt=Instr[11:7], type=Instr[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - shamt=0 passes the operand unchanged for all types; no RRX or #32 forms.
  - Immediate operands (ALUSrcB=01) are never shifted.
- ShiftOp=1: ALUResult=SrcB; N=MSB, Z=(SrcB==0), C=V=0.
- ShiftOp=0:
  - C is the carry-out for add; for sub it is not-borrow.
  - V follows ARM overflow rules for add and sub; C=V=0 for logic ops.
- All arithmetic is mod 2^WIDTH.
- Memory is untimed: ReadData is valid in the same cycle as Adr and is captured into Data at the next edge.
- Reset asserted mid-instruction: all state registers clear at once. The controller's next fetch then reads RESET_PC.

Decomposition:
- Package arm_dp_pkg holds:
  - enums alu_op_t, shift_t, result_src_t, alusrcb_t, imm_src_t;
  - constant PC_INC=4 and R15 index.
- One sub-module, barrel_shifter #(WIDTH) (operand, shamt, type -> result), guarded by SHIFT_EN.
- Register file, flops, muxes, adder and extender reuse existing primitives. Flops use a new enable-flop variant with async reset.

Test Plan:
- Reset mid-run with PC=0x40 -> PC=0x0 in the same cycle, Adr=0x0, Instr=0, ALUOut=0.
- Fetch cycle with mem[0]=0xE3A01005 and PCWrite=IRWrite=1 -> next cycle Instr=0xE3A01005, PC=0x4; R15 read returns 0x8.
- R2=0x80000001; MOV R3,R2,ROR #1 via ALUSrcB=00, ShiftOp=1 -> ALUResult=0xC0000000, N=1, Z=0, C=V=0; R3 written on the writeback edge.
- ASR #4 of 0xF0000000 -> 0xFF000000. LSR #4 of the same -> 0x0F000000. LSL #0 -> 0xF0000000 unchanged.
- ADD 0x7FFFFFFF+1 -> 0x80000000 with N=1, V=1, C=0. SUB 5-5 -> 0 with Z=1, C=1.
- LDR: base R1=0x100, imm 8, ReadData=0xDEADBEEF.
  - Adr=0x108 in the memory cycle.
  - Data=0xDEADBEEF one cycle later.
  - ResultSrc=01 writes Rd=0xDEADBEEF.
- SHIFT_EN=0 build: ROR instruction encoding -> SrcB equals WriteData unshifted.

Source files
------------

// File: rtl/arm_multicycle_datapath_pkg.sv
// Shared types and constants for the multicycle ARM datapath and its controller.
package arm_dp_pkg;

   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_op_t;
   typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;
   typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10} result_src_t;
   typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alusrcb_t;
   typedef enum logic [1:0] {IMM_8 = 2'b00, IMM_12 = 2'b01, IMM_BR = 2'b10} imm_src_t;

   localparam int         PC_INC = 4;
   localparam logic [3:0] R15    = 4'd15;

endpackage

// File: rtl/arm_multicycle_datapath_if.sv
// Controller <-> datapath bundle: control strobes, memory port and status back to the FSM.
interface arm_multicycle_datapath_if
   import arm_dp_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             PCWrite;
   logic             AdrSrc;
   logic             IRWrite;
   logic [1:0]       RegSrc;
   logic             RegWrite;
   imm_src_t         ImmSrc;
   logic             ALUSrcA;
   alusrcb_t         ALUSrcB;
   alu_op_t          ALUControl;
   logic             ShiftOp;
   result_src_t      ResultSrc;
   logic [WIDTH-1:0] Adr;
   logic [WIDTH-1:0] WriteData;
   logic [WIDTH-1:0] ReadData;
   logic [31:0]      Instr;
   logic [3:0]       ALUFlags;

   modport master (
      output PCWrite, AdrSrc, IRWrite, RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB,
             ALUControl, ShiftOp, ResultSrc, ReadData,
      input  Adr, WriteData, Instr, ALUFlags
   );

   modport slave (
      input  PCWrite, AdrSrc, IRWrite, RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB,
             ALUControl, ShiftOp, ResultSrc, ReadData,
      output Adr, WriteData, Instr, ALUFlags
   );
endinterface

// File: rtl/arm_multicycle_datapath_barrel_shifter.sv
// Register-operand shifter; a zero shift amount passes the operand through for every type.
module barrel_shifter
   import arm_dp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] operand,
   input  logic [4:0]       shamt,
   input  shift_t           shift_type,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = operand;
      if (shamt != 5'd0) begin
         case (shift_type)
            SH_LSL:  result = operand << shamt;
            SH_LSR:  result = operand >> shamt;
            SH_ASR:  result = $unsigned($signed(operand) >>> shamt);
            SH_ROR:  result = (operand >> shamt) | (operand << (WIDTH - int'(shamt)));
            default: result = operand;
         endcase
      end
   end

endmodule

// File: rtl/arm_multicycle_datapath.sv
// Multicycle ARM datapath: PC, IR, Data, A, WriteData, ALUOut, register file, shifter and ALU.
module arm_multicycle_datapath
   import arm_dp_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter bit               SHIFT_EN = 1'b1
) (
   input logic                      clk,
   input logic                      reset,
   arm_multicycle_datapath_if.slave dp
);

   logic [WIDTH-1:0] pc_q, pc_d, data_q, data_d, a_q, a_d, wd_q, wd_d, alu_out_q, alu_out_d;
   logic [31:0]      ir_q, ir_d;
   logic [WIDTH-1:0] rf [16];
   logic [3:0]       ra1, ra2, wa;
   logic [WIDTH-1:0] pc_plus4, rd1, rd2, ext_imm, shifted, src_a, src_b, alu_result, result;
   logic [WIDTH:0]   sum;
   logic             flag_c, flag_v;

   assign ra1      = dp.RegSrc[0] ? R15 : ir_q[19:16];
   assign ra2      = dp.RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
   assign wa       = ir_q[15:12];
   assign pc_plus4 = pc_q + WIDTH'(PC_INC);

   // R15 is never stored; reading it yields the already-advanced PC plus 4.
   assign rd1 = (ra1 == R15) ? pc_plus4 : rf[ra1];
   assign rd2 = (ra2 == R15) ? pc_plus4 : rf[ra2];

   always_ff @(posedge clk) begin
      if (dp.RegWrite && (wa != R15)) begin
         rf[wa] <= result;
      end
   end

   always_comb begin
      case (dp.ImmSrc)
         IMM_8:   ext_imm = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
         IMM_12:  ext_imm = {{(WIDTH-12){1'b0}}, ir_q[11:0]};
         IMM_BR:  ext_imm = {{(WIDTH-26){ir_q[23]}}, ir_q[23:0], 2'b00};
         default: ext_imm = '0;
      endcase
   end

   if (SHIFT_EN) begin : g_shift
      barrel_shifter #(.WIDTH(WIDTH)) u_shift (
         .operand    (wd_q),
         .shamt      (ir_q[11:7]),
         .shift_type (shift_t'(ir_q[6:5])),
         .result     (shifted)
      );
   end else begin : g_noshift
      assign shifted = wd_q;
   end

   assign src_a = dp.ALUSrcA ? pc_q : a_q;

   always_comb begin
      case (dp.ALUSrcB)
         SRCB_REG:  src_b = shifted;
         SRCB_IMM:  src_b = ext_imm;
         SRCB_FOUR: src_b = WIDTH'(PC_INC);
         default:   src_b = shifted;
      endcase
   end

   // Subtraction adds the inverted operand plus one, so the carry out is ARM's not-borrow.
   always_comb begin
      sum        = '0;
      alu_result = '0;
      flag_c     = 1'b0;
      flag_v     = 1'b0;
      if (dp.ShiftOp) begin
         alu_result = src_b;
      end else begin
         case (dp.ALUControl)
            ALU_ADD: begin
               sum        = {1'b0, src_a} + {1'b0, src_b};
               alu_result = sum[WIDTH-1:0];
               flag_c     = sum[WIDTH];
               flag_v     = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
               sum        = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
               alu_result = sum[WIDTH-1:0];
               flag_c     = sum[WIDTH];
               flag_v     = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: alu_result = src_a & src_b;
            ALU_ORR: alu_result = src_a | src_b;
            default: alu_result = '0;
         endcase
      end
   end

   always_comb begin
      case (dp.ResultSrc)
         RES_ALUOUT: result = alu_out_q;
         RES_DATA:   result = data_q;
         RES_ALU:    result = alu_result;
         default:    result = alu_out_q;
      endcase
   end

   always_comb begin
      pc_d      = dp.PCWrite ? result : pc_q;
      ir_d      = dp.IRWrite ? dp.ReadData[31:0] : ir_q;
      data_d    = dp.ReadData;
      a_d       = rd1;
      wd_d      = rd2;
      alu_out_d = alu_result;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         data_q    <= '0;
         a_q       <= '0;
         wd_q      <= '0;
         alu_out_q <= '0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         data_q    <= data_d;
         a_q       <= a_d;
         wd_q      <= wd_d;
         alu_out_q <= alu_out_d;
      end
   end

   assign dp.Adr       = dp.AdrSrc ? result : pc_q;
   assign dp.WriteData = wd_q;
   assign dp.Instr     = ir_q;
   assign dp.ALUFlags  = {alu_result[WIDTH-1], (alu_result == '0), flag_c, flag_v};

endmodule

// File: tb/tb_arm_multicycle_datapath.sv
// Directed bench: a shifting and a non-shifting datapath share one controller stimulus stream.
module tb_arm_multicycle_datapath;
   import arm_dp_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] instr;
      alusrcb_t    srcb;
      imm_src_t    imm;
      alu_op_t     op;
      logic        shop;
      logic [31:0] exp;
      logic [3:0]  flags;
      logic [31:0] exp_ns;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_vectors = 0;
   int   n_miscompares = 0;
   vec_t vecs[$];

   arm_multicycle_datapath_if #(.WIDTH(32)) ifc ();
   arm_multicycle_datapath_if #(.WIDTH(32)) ifc_ns ();

   arm_multicycle_datapath #(.WIDTH(32), .RESET_PC(32'h0), .SHIFT_EN(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .dp    (ifc)
   );

   arm_multicycle_datapath #(.WIDTH(32), .RESET_PC(32'h0), .SHIFT_EN(1'b0)) u_dut_ns (
      .clk   (clk),
      .reset (reset),
      .dp    (ifc_ns)
   );

   assign ifc_ns.PCWrite    = ifc.PCWrite;
   assign ifc_ns.AdrSrc     = ifc.AdrSrc;
   assign ifc_ns.IRWrite    = ifc.IRWrite;
   assign ifc_ns.RegSrc     = ifc.RegSrc;
   assign ifc_ns.RegWrite   = ifc.RegWrite;
   assign ifc_ns.ImmSrc     = ifc.ImmSrc;
   assign ifc_ns.ALUSrcA    = ifc.ALUSrcA;
   assign ifc_ns.ALUSrcB    = ifc.ALUSrcB;
   assign ifc_ns.ALUControl = ifc.ALUControl;
   assign ifc_ns.ShiftOp    = ifc.ShiftOp;
   assign ifc_ns.ResultSrc  = ifc.ResultSrc;
   assign ifc_ns.ReadData   = ifc.ReadData;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic setIdle();
      ifc.PCWrite    = 1'b0;
      ifc.AdrSrc     = 1'b0;
      ifc.IRWrite    = 1'b0;
      ifc.RegSrc     = 2'b00;
      ifc.RegWrite   = 1'b0;
      ifc.ImmSrc     = IMM_8;
      ifc.ALUSrcA    = 1'b0;
      ifc.ALUSrcB    = SRCB_REG;
      ifc.ALUControl = ALU_ADD;
      ifc.ShiftOp    = 1'b0;
      ifc.ResultSrc  = RES_ALUOUT;
   endtask

   // Rd comes from the IR, so a register is written by loading IR, then Data, then committing Data.
   task automatic writeReg(input logic [3:0] rd, input logic [31:0] val);
      setIdle();
      ifc.IRWrite  = 1'b1;
      ifc.ReadData = {16'h0000, rd, 12'h000};
      tick();
      ifc.IRWrite  = 1'b0;
      ifc.ReadData = val;
      tick();
      ifc.ResultSrc = RES_DATA;
      ifc.RegWrite  = 1'b1;
      tick();
      ifc.RegWrite  = 1'b0;
   endtask

   task automatic loadIr(input logic [31:0] instr);
      setIdle();
      ifc.IRWrite  = 1'b1;
      ifc.ReadData = instr;
      tick();
      ifc.IRWrite  = 1'b0;
      tick();
   endtask

   task automatic setFetch();
      setIdle();
      ifc.ALUSrcA   = 1'b1;
      ifc.ALUSrcB   = SRCB_FOUR;
      ifc.ResultSrc = RES_ALU;
      ifc.PCWrite   = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      writeReg(4'd1, v.a);
      writeReg(4'd2, v.b);
      loadIr(v.instr);
      ifc.ALUSrcB    = v.srcb;
      ifc.ImmSrc     = v.imm;
      ifc.ALUControl = v.op;
      ifc.ShiftOp    = v.shop;
      ifc.ResultSrc  = RES_ALU;
      ifc.AdrSrc     = 1'b1;
      #1;
      checkOutput({v.name, " result"}, ifc.Adr, v.exp);
      checkOutput({v.name, " flags"}, {28'h0, ifc.ALUFlags}, {28'h0, v.flags});
      checkOutput({v.name, " noshift"}, ifc_ns.Adr, v.exp_ns);
   endtask

   initial begin
      vecs.push_back(vec_t'{"ror1",   32'h0,        32'h80000001, 32'hE00130E2, SRCB_REG,  IMM_8,  ALU_ADD, 1'b1, 32'hC0000000, 4'b1000, 32'h80000001});
      vecs.push_back(vec_t'{"asr4",   32'h0,        32'hF0000000, 32'hE0013242, SRCB_REG,  IMM_8,  ALU_ADD, 1'b1, 32'hFF000000, 4'b1000, 32'hF0000000});
      vecs.push_back(vec_t'{"lsr4",   32'h0,        32'hF0000000, 32'hE0013222, SRCB_REG,  IMM_8,  ALU_ADD, 1'b1, 32'h0F000000, 4'b0000, 32'hF0000000});
      vecs.push_back(vec_t'{"lsl0",   32'h0,        32'hF0000000, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_ADD, 1'b1, 32'hF0000000, 4'b1000, 32'hF0000000});
      vecs.push_back(vec_t'{"lsl4",   32'h0,        32'h12345678, 32'hE0013202, SRCB_REG,  IMM_8,  ALU_ADD, 1'b1, 32'h23456780, 4'b0000, 32'h12345678});
      vecs.push_back(vec_t'{"ror4",   32'h0,        32'h0000000F, 32'hE0013262, SRCB_REG,  IMM_8,  ALU_ADD, 1'b1, 32'hF0000000, 4'b1000, 32'h0000000F});
      vecs.push_back(vec_t'{"addovf", 32'h7FFFFFFF, 32'h00000001, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_ADD, 1'b0, 32'h80000000, 4'b1001, 32'h80000000});
      vecs.push_back(vec_t'{"subz",   32'h00000005, 32'h00000005, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_SUB, 1'b0, 32'h00000000, 4'b0110, 32'h00000000});
      vecs.push_back(vec_t'{"addcz",  32'hFFFFFFFF, 32'h00000001, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_ADD, 1'b0, 32'h00000000, 4'b0110, 32'h00000000});
      vecs.push_back(vec_t'{"subbor", 32'h00000000, 32'h00000001, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_SUB, 1'b0, 32'hFFFFFFFF, 4'b1000, 32'hFFFFFFFF});
      vecs.push_back(vec_t'{"subovf", 32'h80000000, 32'h00000001, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_SUB, 1'b0, 32'h7FFFFFFF, 4'b0011, 32'h7FFFFFFF});
      vecs.push_back(vec_t'{"and",    32'hFF00FF00, 32'h0FF00FF0, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_AND, 1'b0, 32'h0F000F00, 4'b0000, 32'h0F000F00});
      vecs.push_back(vec_t'{"orrz",   32'h00000000, 32'h00000000, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_ORR, 1'b0, 32'h00000000, 4'b0100, 32'h00000000});
      vecs.push_back(vec_t'{"orr",    32'h000000F0, 32'h0000000F, 32'hE0013002, SRCB_REG,  IMM_8,  ALU_ORR, 1'b0, 32'h000000FF, 4'b0000, 32'h000000FF});
      vecs.push_back(vec_t'{"imm8",   32'h00000100, 32'h00000000, 32'hE00130FF, SRCB_IMM,  IMM_8,  ALU_ADD, 1'b0, 32'h000001FF, 4'b0000, 32'h000001FF});
      vecs.push_back(vec_t'{"imm12",  32'h00000000, 32'h00000000, 32'hE0013ABC, SRCB_IMM,  IMM_12, ALU_ADD, 1'b0, 32'h00000ABC, 4'b0000, 32'h00000ABC});
      vecs.push_back(vec_t'{"immbr",  32'h00000100, 32'h00000000, 32'hE0F10000, SRCB_IMM,  IMM_BR, ALU_ADD, 1'b0, 32'hFFC40100, 4'b1000, 32'hFFC40100});
      vecs.push_back(vec_t'{"four",   32'h00000010, 32'h00000000, 32'hE0013002, SRCB_FOUR, IMM_8,  ALU_ADD, 1'b0, 32'h00000014, 4'b0000, 32'h00000014});

      reset        = 1'b1;
      ifc.ReadData = 32'h0;
      setIdle();
      #12;
      checkOutput("reset adr", ifc.Adr, 32'h0);
      checkOutput("reset instr", ifc.Instr, 32'h0);
      checkOutput("reset writedata", ifc.WriteData, 32'h0);
      checkOutput("reset flags", {28'h0, ifc.ALUFlags}, 32'h4);
      reset = 1'b0;
      tick();

      // Fetch from address 0, then read R15 through RA1 and observe A via ADD with imm8=5.
      setFetch();
      ifc.IRWrite  = 1'b1;
      ifc.ReadData = 32'hE3A01005;
      #1;
      checkOutput("fetch adr", ifc.Adr, 32'h0);
      tick();
      setIdle();
      checkOutput("fetch instr", ifc.Instr, 32'hE3A01005);
      checkOutput("fetch pc", ifc.Adr, 32'h4);
      ifc.RegSrc = 2'b01;
      tick();
      ifc.ALUSrcB   = SRCB_IMM;
      ifc.ResultSrc = RES_ALU;
      ifc.AdrSrc    = 1'b1;
      #1;
      checkOutput("r15 ra1", ifc.Adr, 32'hD);

      // Writing R15 must not stick; both read ports still see PC+4.
      writeReg(4'd15, 32'h00001234);
      ifc.RegSrc = 2'b11;
      tick();
      ifc.ALUSrcB   = SRCB_IMM;
      ifc.ResultSrc = RES_ALU;
      ifc.AdrSrc    = 1'b1;
      #1;
      checkOutput("r15 write ignored", ifc.Adr, 32'h8);
      checkOutput("r15 ra2", ifc.WriteData, 32'h8);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // MOV R3, R2, ROR #1 written back, then read through RA2.
      writeReg(4'd2, 32'h80000001);
      loadIr(32'hE00130E2);
      ifc.ShiftOp   = 1'b1;
      ifc.ResultSrc = RES_ALU;
      ifc.RegWrite  = 1'b1;
      tick();
      loadIr(32'hE0000003);
      checkOutput("mov r3", ifc.WriteData, 32'hC0000000);
      checkOutput("mov r3 noshift", ifc_ns.WriteData, 32'h80000001);

      // LDR R4, [R1, #8]
      writeReg(4'd1, 32'h00000100);
      loadIr(32'hE5914008);
      ifc.ALUSrcB = SRCB_IMM;
      ifc.ImmSrc  = IMM_12;
      tick();
      setIdle();
      ifc.AdrSrc    = 1'b1;
      ifc.ResultSrc = RES_ALUOUT;
      ifc.ReadData  = 32'hDEADBEEF;
      #1;
      checkOutput("ldr adr", ifc.Adr, 32'h108);
      tick();
      ifc.ResultSrc = RES_DATA;
      ifc.RegWrite  = 1'b1;
      #1;
      checkOutput("ldr data", ifc.Adr, 32'hDEADBEEF);
      tick();
      loadIr(32'hE0000004);
      checkOutput("ldr r4", ifc.WriteData, 32'hDEADBEEF);

      // Run PC from 4 up to 0x40, then reset mid-cycle.
      setFetch();
      ifc.IRWrite  = 1'b1;
      ifc.ReadData = 32'hE3A01005;
      for (int i = 0; i < 15; i++) tick();
      setIdle();
      #1;
      checkOutput("pc before reset", ifc.Adr, 32'h40);
      reset = 1'b1;
      #1;
      checkOutput("mid reset pc", ifc.Adr, 32'h0);
      checkOutput("mid reset instr", ifc.Instr, 32'h0);
      checkOutput("mid reset writedata", ifc.WriteData, 32'h0);
      ifc.AdrSrc = 1'b1;
      #1;
      checkOutput("mid reset aluout", ifc.Adr, 32'h0);
      ifc.ResultSrc = RES_DATA;
      #1;
      checkOutput("mid reset data", ifc.Adr, 32'h0);
      reset = 1'b0;
      setFetch();
      #1;
      checkOutput("refetch adr", ifc.Adr, 32'h0);
      tick();
      setIdle();
      #1;
      checkOutput("refetch pc", ifc.Adr, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
